// File: rtl/spi_master_n.sv
// SPI master with configurable word width, slave-select count, SCLK divider and CPOL/CPHA.
// One word per start request; the received word is published with a one-cycle done pulse.
module spi_master_n #(
  parameter int DW    = 16,
  parameter int NSS   = 2,
  parameter int DIV_W = 8,
  parameter int SW    = (NSS > 1) ? $clog2(NSS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DW-1:0]    tx_data,
  input  logic [SW-1:0]    ss_sel,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIV_W-1:0] clk_div,
  output logic             busy,
  output logic             done,
  output logic [DW-1:0]    rx_data,
  output logic [NSS-1:0]   ss,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  localparam int            EW        = $clog2(2 * DW + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DW - 1);
  localparam logic [SW:0]   NSS_L     = (SW + 1)'(NSS);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, div_q;
  logic [EW-1:0]    edge_cnt_q;
  logic [DW-1:0]    tx_sh, rx_sh;
  logic             cpha_q;
  logic             tick, accept, edge_en, finish, leading, last_edge;
  logic [NSS-1:0]   sel_oh;

  assign tick      = (cnt_q == '0);
  assign leading   = ~edge_cnt_q[0];
  assign last_edge = (edge_cnt_q == LAST_EDGE);

  always_comb begin
    for (int i = 0; i < NSS; i++) begin
      sel_oh[i] = (ss_sel == SW'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The SETUP->XFER transition is itself the first SCLK edge; XFER waits one
  // extra half-period after the final edge so HOLD starts on a period boundary.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    edge_en = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && ({1'b0, ss_sel} < NSS_L)) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          edge_en = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (tick) begin
          if (edge_cnt_q == EW'(2 * DW)) state_d = HOLD;
          else                           edge_en = 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      div_q <= '0;
    end else if (accept) begin
      cnt_q <= clk_div;
      div_q <= clk_div;
    end else if (state_q != IDLE) begin
      cnt_q <= tick ? div_q : cnt_q - DIV_W'(1);
    end
  end

  // Idle SCLK tracks cpol, so the level at accept is the latched polarity;
  // an even number of toggles returns it there for HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss         <= '1;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rx_data    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      cpha_q     <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) sclk <= cpol;
      if (accept) begin
        ss         <= ~sel_oh;
        busy       <= 1'b1;
        tx_sh      <= tx_data;
        rx_sh      <= '0;
        cpha_q     <= cpha;
        edge_cnt_q <= '0;
        if (!cpha) mosi <= tx_data[DW-1];
      end
      if (edge_en) begin
        sclk       <= ~sclk;
        edge_cnt_q <= edge_cnt_q + EW'(1);
        if (leading ^ cpha_q) begin
          rx_sh <= {rx_sh[DW-2:0], miso};
        end else if (cpha_q) begin
          mosi  <= tx_sh[DW-1];
          tx_sh <= tx_sh << 1;
        end else if (!last_edge) begin
          mosi  <= tx_sh[DW-2];
          tx_sh <= tx_sh << 1;
        end
      end
      if (finish) begin
        ss      <= '1;
        busy    <= 1'b0;
        done    <= 1'b1;
        rx_data <= rx_sh;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_n.sv
// Randomised self-checking bench for spi_master_n against a mode-aware SPI slave model
// and a transfer-level expectation of timing (ss/busy length, edge count, done position).
module tb_spi_master_n;

  localparam int DW    = 16;
  localparam int NSS   = 3;
  localparam int DIV_W = 8;
  localparam int SW    = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [DW-1:0]    tx_data = '0;
  logic [SW-1:0]    ss_sel = '0;
  logic             cpol = 1'b0;
  logic             cpha = 1'b0;
  logic [DIV_W-1:0] clk_div = '0;
  logic             busy, done, sclk, mosi, miso;
  logic [DW-1:0]    rx_data;
  logic [NSS-1:0]   ss;

  int checks = 0;
  int errors = 0;

  // Behavioural slave: shifts out slave_word on its launch edges, collects mosi on its sample edges
  logic [DW-1:0] slave_word = '0;
  logic [DW-1:0] slave_shift = '0;
  logic [DW-1:0] slave_got = '0;
  logic          slave_cpol = 1'b0;
  logic          slave_cpha = 1'b0;
  logic          slave_miso = 1'b0;
  logic          loopback = 1'b0;
  int            slave_sel = 0;
  logic          sel_line;

  assign sel_line = ss[slave_sel];
  assign miso     = loopback ? mosi : slave_miso;

  always #5 clk = ~clk;

  spi_master_n #(.DW(DW), .NSS(NSS), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .ss_sel(ss_sel),
    .cpol(cpol), .cpha(cpha), .clk_div(clk_div), .busy(busy), .done(done),
    .rx_data(rx_data), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  always @(negedge sel_line) begin
    slave_shift = slave_word;
    slave_got   = '0;
    if (!slave_cpha) begin
      slave_miso  = slave_shift[DW-1];
      slave_shift = slave_shift << 1;
    end
  end

  always @(sclk) begin
    if (sel_line === 1'b0) begin
      if ((sclk != slave_cpol) ^ slave_cpha) begin
        slave_got = {slave_got[DW-2:0], mosi};
      end else begin
        slave_miso  = slave_shift[DW-1];
        slave_shift = slave_shift << 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full transfer, monitored cycle by cycle at negedge; expectations come from the
  // transfer length (div+1)*(2*DW+2), the DW rising... edges and the word the slave returns.
  task automatic applyStimulus(input string tag, input logic [DW-1:0] tx, input int sel,
                               input logic pol, input logic pha, input int div,
                               input logic [DW-1:0] sw, input logic loop, input logic poke_busy);
    int   exp_len, busy_cycles, ss_cycles, rises, dones, done_at;
    logic prev_sclk, other_low, rx_moved;
    logic [DW-1:0] prev_rx;
    logic [NSS-1:0] own_bit;
    exp_len     = (div + 1) * (2 * DW + 2);
    busy_cycles = 0; ss_cycles = 0; rises = 0; dones = 0; done_at = -1;
    other_low   = 1'b0; rx_moved = 1'b0;
    own_bit     = NSS'(1) << sel;
    @(negedge clk);
    cpol = pol; cpha = pha; clk_div = DIV_W'(div);
    slave_cpol = pol; slave_cpha = pha; slave_sel = sel; slave_word = sw; loopback = loop;
    @(negedge clk);
    tx_data = tx; ss_sel = SW'(sel); start = 1'b1;
    prev_rx = rx_data;
    @(negedge clk);
    start = 1'b0;
    prev_sclk = sclk;
    for (int cyc = 0; cyc < exp_len + 4; cyc++) begin
      if (busy) busy_cycles++;
      if (ss[sel] == 1'b0) ss_cycles++;
      if (((~ss) & ~own_bit) != '0) other_low = 1'b1;
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
      if (done) begin
        dones++;
        if (done_at < 0) done_at = cyc;
      end
      if (done_at < 0 && rx_data !== prev_rx) rx_moved = 1'b1;
      if (poke_busy) begin
        if (cyc >= 3 && cyc < 7) begin
          start = 1'b1; tx_data = ~tx; cpha = ~pha; clk_div = DIV_W'(div + 1);
        end else if (cyc == 7) begin
          start = 1'b0; tx_data = tx; cpha = pha; clk_div = DIV_W'(div);
        end
      end
      @(negedge clk);
    end
    checkOutput({tag, "_busy_len"}, busy_cycles, exp_len);
    checkOutput({tag, "_ss_len"}, ss_cycles, exp_len);
    checkOutput({tag, "_sclk_rises"}, rises, DW);
    checkOutput({tag, "_done_count"}, dones, 1);
    checkOutput({tag, "_done_at"}, done_at, exp_len);
    checkOutput({tag, "_other_ss"}, other_low, 1'b0);
    checkOutput({tag, "_rx_stable"}, rx_moved, 1'b0);
    checkOutput({tag, "_rx"}, rx_data, loop ? tx : sw);
    checkOutput({tag, "_slave_saw_mosi"}, slave_got, tx);
    checkOutput({tag, "_sclk_idle"}, sclk, pol);
    checkOutput({tag, "_mosi_final"}, mosi, tx[0]);
    checkOutput({tag, "_ss_idle"}, ss, {NSS{1'b1}});
  endtask

  initial begin
    int   waited;
    logic bad;
    logic [DW-1:0] word_a, word_b;
    $display("[TB] spi_master_n bench start");

    #1 reset = 1'b1;
    cpol = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_ss", ss, {NSS{1'b1}});
    checkOutput("reset_sclk", sclk, 1'b0);
    checkOutput("reset_mosi", mosi, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_rx", rx_data, '0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("release_sclk_cpol", sclk, 1'b1);
    cpol = 1'b0;

    applyStimulus("loop_m0", 16'hA5C3, 0, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0);
    applyStimulus("m3", 16'h8001, 1, 1'b1, 1'b1, 3, 16'h1234, 1'b0, 1'b0);
    applyStimulus("m1", DW'($urandom), 0, 1'b0, 1'b1, 0, DW'($urandom), 1'b0, 1'b0);
    applyStimulus("m2", DW'($urandom), 2, 1'b1, 1'b0, 0, DW'($urandom), 1'b0, 1'b0);
    applyStimulus("busy_poke", 16'h3C5A, 0, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b1);

    // Back-to-back: start on the done cycle must give exactly one ss-high cycle
    word_a = DW'($urandom);
    word_b = DW'($urandom);
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; clk_div = '0; loopback = 1'b1; slave_sel = 0;
    @(negedge clk);
    tx_data = word_a; ss_sel = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!done && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("b2b_first_timeout", waited < 200, 1'b1);
    checkOutput("b2b_first_rx", rx_data, word_a);
    checkOutput("b2b_gap_ss", ss, {NSS{1'b1}});
    tx_data = word_b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_second_ss", ss, 3'b110);
    checkOutput("b2b_second_busy", busy, 1'b1);
    waited = 0;
    while (!done && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("b2b_second_timeout", waited < 200, 1'b1);
    checkOutput("b2b_second_rx", rx_data, word_b);

    // Out-of-range slave index is ignored entirely
    @(negedge clk);
    tx_data = 16'hFFFF; ss_sel = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (busy || done || ss != {NSS{1'b1}}) bad = 1'b1;
      @(negedge clk);
    end
    checkOutput("bad_sel_ignored", bad, 1'b0);
    checkOutput("bad_sel_rx_kept", rx_data, word_b);
    applyStimulus("sel1", DW'($urandom), 1, 1'b0, 1'b0, 2, DW'($urandom), 1'b0, 1'b0);

    // Reset in the middle of a transfer
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1; loopback = 1'b1; slave_sel = 0;
    @(negedge clk);
    tx_data = 16'h5AA5; ss_sel = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_ss", ss, {NSS{1'b1}});
    checkOutput("midrst_sclk", sclk, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_rx", rx_data, '0);
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (busy || done) bad = 1'b1;
      @(negedge clk);
    end
    checkOutput("midrst_no_resume", bad, 1'b0);
    applyStimulus("after_rst", 16'hC0DE, 0, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0);

    for (int n = 0; n < 6; n++) begin
      int   mode;
      mode = int'($urandom_range(0, 3));
      applyStimulus($sformatf("rand%0d", n), DW'($urandom), int'($urandom_range(0, 2)),
                    mode[1], mode[0], int'($urandom_range(0, 3)), DW'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_n.md
# spi_master_n

Parametrised SPI master for the MCU peripheral set. It replaces the fixed single-slave SPI pins (ss/sclk/mosi/miso) with a master that has configurable word width, slave-select count, SCLK divider and all four CPOL/CPHA modes. The master serialises one word per start request and returns the received word with a one-cycle done pulse. It sits between the MCU register/bus logic and the SPI pads.

## Interface
- DW, 16: transfer word width in bits (≥2)
- NSS, 2: number of slave-select lines (≥1)
- DIV_W, 8: width of clock-divider field
- SW, $clog2(NSS) (min 1): width of ss_sel
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  transfer request, sampled only while busy=0
- tx_data  in  DW  word to send, MSB first
- ss_sel  in  SW  slave index for this transfer
- cpol  in  1  SCLK idle level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- clk_div  in  DIV_W  SCLK half-period = clk_div+1 clk cycles
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at end of transfer
- rx_data  out  DW  last received word
- ss  out  NSS  active-low slave selects
- sclk  out  1  SPI clock
- mosi  out  1  serial data out
- miso  in  1  serial data in

## Operation
- States: IDLE, SETUP, XFER, HOLD. A half-period counter is reloaded with clk_div at every state entry and every SCLK edge.
- IDLE: ss all 1, sclk follows cpol (registered), busy=0.
  - start=1 with ss_sel<NSS latches tx_data, ss_sel, cpol, cpha and clk_div, then enters SETUP.
  - start with ss_sel≥NSS is ignored: no state change and no done.
- SETUP: ss[sel]=0 and busy=1. With cpha=0, mosi=tx_data[DW-1] from SETUP entry. Lasts clk_div+1 cycles.
- XFER: 2·DW SCLK edges, one every clk_div+1 cycles; an edge counter counts them.
  - cpha=0: on the leading edge, capture miso. On the trailing edge, shift the next bit onto mosi; no shift after the final edge.
  - cpha=1: on the leading edge, drive the next bit (MSB on the first edge). On the trailing edge, capture miso.
  - Capture: miso is sampled on the same clk edge that toggles sclk to the sampling level.
  - Received bits shift in MSB first.
- HOLD: ss stays asserted and sclk sits at the idle level, for clk_div+1 cycles.
- HOLD exit, on one clk edge: ss all 1, busy=0, done=1 for one cycle, rx_data updated. Then return to IDLE.
- start, tx_data and config are ignored while busy=1. Config changes mid-transfer have no effect.
- start on the done cycle is accepted, which gives back-to-back transfers.
- After the last transfer, mosi holds its final value.

## Timing
- Reset values: ss all 1, sclk 0, mosi 0, busy 0, done 0, rx_data 0, state IDLE.
- Reset takes effect immediately, including mid-transfer. The partial word is discarded and there is no done pulse.
- The first cycle after reset release shows sclk = cpol.
- Latency: start sampled at edge T0 gives busy=1 and ss low from T0. done is high in the cycle after edge T0+(clk_div+1)·(2·DW+2).
- SCLK frequency is f_clk/(2·(clk_div+1)). clk_div=0 gives f_clk/2 with 1-cycle phases.
- ss is asserted for (clk_div+1)·(2·DW+2) cycles. The minimum ss-high gap between back-to-back transfers is 1 cycle.
- rx_data is stable from done until the next done. It does not change during a transfer.

## Test plan
- Loopback (miso=mosi), mode 0, DW=16, clk_div=1, tx 0xA5C3, ss_sel=0 -> ss[0] low for exactly 68 cycles, 16 rising sclk edges, rx_data=0xA5C3, a single done pulse, ss[1] stays high.
- Mode 3 (cpol=1, cpha=1), slave model returns 0x1234 on trailing edges, clk_div=3 -> sclk idles high before and after, busy=136 cycles, rx_data=0x1234; mosi is checked bitwise against tx 0x8001.
- Modes 1 and 2 against a mode-matched slave model, clk_div=0 -> sclk period 2 clks, rx correct, busy=34 cycles.
- start pulses while busy with a different tx_data -> ignored, original word completes. start on the done cycle -> second transfer begins with a 1-cycle ss gap.
- ss_sel=2 with NSS=2 -> no busy, no ss activity, no done. Then ss_sel=1 -> ss[1] used.
- Assert reset at edge 10 of a transfer -> ss all 1, sclk 0, busy 0 in the same cycle, rx_data=0, no done. A new transfer after release completes correctly.
